// File: rtl/fib_scheduler_if.sv
// fib_scheduler_if
//   Bundles the request and response channels of the shared Fibonacci
//   engine so clients and the scheduler connect through one port.
//
//   Parameters:
//     NREQ  - number of requesters
//     WIDTH - width of each requested index n
//     IDW   - requester-index width (2**IDW >= NREQ)
//
//   Signals:
//     req_valid  per-requester request valid          (client -> engine)
//     req_n      packed indices, requester k at [k*WIDTH +: WIDTH]
//     req_ready  one-hot grant                        (engine -> client)
//     busy       engine is not idle                   (engine -> client)
//     rsp_valid  result available                     (engine -> consumer)
//     rsp_ready  consumer accepts result              (consumer -> engine)
//     rsp_id     requester that owns the result       (engine -> consumer)
//     rsp_fib    F(n) mod 2**32                       (engine -> consumer)
interface fib_scheduler_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_n;
  logic [NREQ-1:0]       req_ready;
  logic                  busy;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [31:0]           rsp_fib;

  // Requester/consumer side.
  modport master (
    output req_valid, req_n, rsp_ready,
    input  req_ready, busy, rsp_valid, rsp_id, rsp_fib
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_n, rsp_ready,
    output req_ready, busy, rsp_valid, rsp_id, rsp_fib
  );
endinterface

// File: rtl/fib_scheduler.sv
// fib_scheduler
//   Sequential Fibonacci engine shared by NREQ requesters. A round-robin
//   arbiter grants one request at a time; the accepted index n is walked
//   down one recurrence step per clock on a single 32-bit adder, and the
//   result is returned with the owner's index on a valid/ready channel.
//
//   Ports:
//     clk    - clock, rising-edge
//     rst_n  - asynchronous active-low reset
//     bus    - fib_scheduler_if.slave (request/response channels)
module fib_scheduler #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  fib_scheduler_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_reg;
  logic [IDW-1:0]   ptr_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [IDW-1:0]   id_reg;
  logic [31:0]      a_reg;
  logic [31:0]      b_reg;
  logic [31:0]      rsp_fib_reg;
  logic [IDW-1:0]   rsp_id_reg;
  logic             rsp_valid_reg;
  logic             busy_reg;

  // Unpacked view of the packed index bus.
  logic [WIDTH-1:0] n_arr [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign n_arr[gi] = bus.req_n[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Round-robin search starting at ptr_reg. Only active in IDLE, so the
  // grant never depends on the response channel.
  logic [NREQ-1:0] grant_onehot;
  logic [IDW-1:0]  grant_idx;
  logic            grant_found;

  always_comb begin
    int idx;
    grant_onehot = '0;
    grant_idx    = '0;
    grant_found  = 1'b0;
    idx          = 0;
    if (state_reg == IDLE) begin
      for (int i = 0; i < NREQ; i++) begin
        idx = int'(ptr_reg) + i;
        if (idx >= NREQ) begin
          idx = idx - NREQ;
        end
        if (!grant_found && bus.req_valid[idx]) begin
          grant_found       = 1'b1;
          grant_idx         = IDW'(idx);
          grant_onehot[idx] = 1'b1;
        end
      end
    end
  end

  // Pointer moves to the requester after the winner, wrapping at NREQ
  // (which need not be a power of two).
  logic [IDW-1:0] ptr_after_grant;
  assign ptr_after_grant = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      rem_reg       <= '0;
      id_reg        <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      rsp_fib_reg   <= '0;
      rsp_id_reg    <= '0;
      rsp_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_found) begin
            rem_reg   <= n_arr[grant_idx];
            id_reg    <= grant_idx;
            a_reg     <= 32'd0;
            b_reg     <= 32'd1;
            ptr_reg   <= ptr_after_grant;
            state_reg <= CALC;
            busy_reg  <= 1'b1;
          end
        end
        CALC: begin
          if (rem_reg != '0) begin
            // a holds F(k), b holds F(k+1); sum wraps modulo 2**32.
            a_reg   <= b_reg;
            b_reg   <= a_reg + b_reg;
            rem_reg <= rem_reg - 1'b1;
          end else begin
            rsp_fib_reg   <= a_reg;
            rsp_id_reg    <= id_reg;
            rsp_valid_reg <= 1'b1;
            state_reg     <= RESP;
          end
        end
        RESP: begin
          // Result registers hold until the consumer takes them; the
          // arbiter re-opens only once we are back in IDLE.
          if (bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          rsp_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = grant_onehot;
  assign bus.busy      = busy_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_id    = rsp_id_reg;
  assign bus.rsp_fib   = rsp_fib_reg;

endmodule

// File: tb/tb_fib_scheduler.sv
module tb_fib_scheduler;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;

  logic clk;
  logic rst_n;

  fib_scheduler_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

  fib_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  typedef struct {
    int          id;
    logic [31:0] fib;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    int          id;
    int          n;
    logic [31:0] fib;
  } vec_t;

  function automatic logic [31:0] fib_ref(input int n);
    logic [31:0] x, y, t;
    x = 32'd0;
    y = 32'd1;
    for (int i = 0; i < n; i++) begin
      t = x + y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end else begin
      passed++;
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Scoreboard: pop an expectation on every response handshake.
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_id", 64'(bus.rsp_id), 64'(e.id));
        chk("rsp_fib", 64'(bus.rsp_fib), 64'(e.fib));
      end
    end
  end

  // Single request from one requester, checking grant, latency and busy.
  task automatic run_req(input int id, input int n, input logic [31:0] fib);
    int cyc;
    bit seen;
    bit busy_ok;
    exp_t e;
    @(negedge clk);
    bus.req_valid[id] = 1'b1;
    bus.req_n[id*WIDTH +: WIDTH] = WIDTH'(n);
    #1;
    chk($sformatf("grant_r%0d_n%0d", id, n), 64'(bus.req_ready), 64'(1 << id));
    @(posedge clk);
    e.id = id;
    e.fib = fib;
    sb.push_back(e);
    #1;
    bus.req_valid[id] = 1'b0;
    cyc = 0;
    seen = 0;
    busy_ok = 1;
    while (!seen && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (!bus.busy) busy_ok = 0;
      if (bus.rsp_valid) seen = 1;
    end
    chk("rsp_seen", 64'(seen), 64'd1);
    chk($sformatf("latency_n%0d", n), 64'(cyc), 64'(n + 2));
    chk("busy_during", 64'(busy_ok), 64'd1);
    @(posedge clk);
    @(negedge clk);
    chk("busy_after", 64'(bus.busy), 64'd0);
    chk("rsp_valid_after", 64'(bus.rsp_valid), 64'd0);
  endtask

  initial begin
    vec_t vecs[7];
    exp_t e;
    int cyc;
    bit ok;

    vecs[0] = '{0, 10, 32'd55};
    vecs[1] = '{1, 0, 32'd0};
    vecs[2] = '{2, 1, 32'd1};
    vecs[3] = '{3, 2, 32'd1};
    vecs[4] = '{0, 47, 32'd2971215073};
    vecs[5] = '{1, 48, 32'd512559680};
    vecs[6] = '{3, 255, fib_ref(255)};

    bus.req_valid = '0;
    bus.req_n     = '0;
    bus.rsp_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_req_ready", 64'(bus.req_ready), 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("reset_rsp_id", 64'(bus.rsp_id), 64'd0);
    chk("reset_rsp_fib", 64'(bus.rsp_fib), 64'd0);
    rst_n = 1'b1;

    // Table-driven single requests (last id 3 leaves ptr at 0).
    for (int v = 0; v < 7; v++) begin
      run_req(vecs[v].id, vecs[v].n, vecs[v].fib);
    end

    // Round robin: all four held valid, n = k+3.
    @(negedge clk);
    for (int k = 0; k < NREQ; k++) begin
      bus.req_n[k*WIDTH +: WIDTH] = WIDTH'(k + 3);
    end
    bus.req_valid = '1;
    for (int g = 0; g < 5; g++) begin
      cyc = 0;
      #1;
      while (bus.req_ready == '0 && cyc < 100) begin
        @(negedge clk);
        #1;
        cyc++;
      end
      chk($sformatf("rr_grant%0d", g), 64'(bus.req_ready), 64'(1 << (g % NREQ)));
      e.id = g % NREQ;
      e.fib = fib_ref((g % NREQ) + 3);
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (g == 4) bus.req_valid = '0;
      @(negedge clk);
    end
    cyc = 0;
    while (sb.size() != 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("rr_drained", 64'(sb.size()), 64'd0);
    @(negedge clk);

    // Backpressure: ptr now 1; requester 1 (n=6) wins over pending 3 (n=4).
    bus.rsp_ready = 1'b0;
    bus.req_n[1*WIDTH +: WIDTH] = 8'd6;
    bus.req_n[3*WIDTH +: WIDTH] = 8'd4;
    bus.req_valid[1] = 1'b1;
    bus.req_valid[3] = 1'b1;
    #1;
    chk("bp_grant", 64'(bus.req_ready), 64'b0010);
    @(posedge clk);
    e.id = 1;
    e.fib = 32'd8;
    sb.push_back(e);
    #1;
    bus.req_valid[1] = 1'b0;
    cyc = 0;
    @(negedge clk);
    while (!bus.rsp_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("bp_rsp_seen", 64'(bus.rsp_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_hold%0d_fib", i), 64'(bus.rsp_fib), 64'd8);
      chk($sformatf("bp_hold%0d_id", i), 64'(bus.rsp_id), 64'd1);
      chk($sformatf("bp_hold%0d_ready", i), 64'(bus.req_ready), 64'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    // Response handshake cycle: still no grant.
    chk("bp_accept_ready", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    // First IDLE cycle: pending requester 3 is granted.
    chk("bp_next_grant", 64'(bus.req_ready), 64'b1000);
    e.id = 3;
    e.fib = 32'd3;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.req_valid[3] = 1'b0;
    cyc = 0;
    while (sb.size() != 0 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("bp_drained", 64'(sb.size()), 64'd0);
    @(negedge clk);
    @(negedge clk);

    // Reset mid-CALC: requester 1, n=20, reset pulse at T+5.
    bus.req_n[1*WIDTH +: WIDTH] = 8'd20;
    bus.req_valid[1] = 1'b1;
    @(posedge clk);
    e.id = 1;
    e.fib = fib_ref(20);
    sb.push_back(e);
    #1;
    bus.req_valid[1] = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("mid_rst_rsp_id", 64'(bus.rsp_id), 64'd0);
    chk("mid_rst_rsp_fib", 64'(bus.rsp_fib), 64'd0);
    chk("mid_rst_req_ready", 64'(bus.req_ready), 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    ok = 1;
    repeat (30) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.busy) ok = 0;
    end
    chk("no_rsp_after_rst", 64'(ok), 64'd1);
    // ptr back at 0: with 1 and 2 both valid, 1 wins.
    bus.req_n[2*WIDTH +: WIDTH] = 8'd5;
    bus.req_valid[1] = 1'b1;
    bus.req_valid[2] = 1'b1;
    #1;
    chk("ptr_reset_grant", 64'(bus.req_ready), 64'b0010);
    bus.req_valid[1] = 1'b0;
    #1;
    chk("drop_valid_grant", 64'(bus.req_ready), 64'b0100);
    bus.req_valid[2] = 1'b0;
    run_req(2, 5, 32'd5);

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end
endmodule
